// File: rtl/cpu_bus_arbiter.sv
// Two-master arbiter for the CPU memory bus: port A (fetch, read-only), port B (load/store).
// Registered single-outstanding transfer, round-robin on contention, watchdog abort.
module cpu_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned TIMEOUT_WIDTH  = 16
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_pa_request,
  output logic        o_pa_ready,
  input  logic [31:0] i_pa_address,
  output logic [31:0] o_pa_rdata,
  input  logic        i_pb_request,
  input  logic        i_pb_rw,
  output logic        o_pb_ready,
  input  logic [31:0] i_pb_address,
  input  logic [31:0] i_pb_wdata,
  output logic [31:0] o_pb_rdata,
  output logic        o_bus_request,
  output logic        o_bus_rw,
  input  logic        i_bus_ready,
  output logic [31:0] o_bus_address,
  input  logic [31:0] i_bus_rdata,
  output logic [31:0] o_bus_wdata,
  output logic        o_busy,
  output logic        o_timeout
);

  // IDLE: waiting for a request | BUS_A/BUS_B: transfer in flight | RELEASE: ready pulse cycle
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUS_A   = 2'd1,
    BUS_B   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [TIMEOUT_WIDTH-1:0] WD_LIMIT =
    TIMEOUT_WIDTH'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  state_t                   state;
  logic                     last_grant_b;
  logic [TIMEOUT_WIDTH-1:0] watchdog;
  logic                     wd_expire;
  logic [31:0]              done_rdata;

  assign wd_expire  = (TIMEOUT_CYCLES != 0) && (watchdog == WD_LIMIT);
  assign done_rdata = i_bus_ready ? i_bus_rdata : 32'd0;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state         <= IDLE;
      last_grant_b  <= 1'b1;
      watchdog      <= '0;
      o_pa_ready    <= 1'b0;
      o_pa_rdata    <= 32'd0;
      o_pb_ready    <= 1'b0;
      o_pb_rdata    <= 32'd0;
      o_bus_request <= 1'b0;
      o_bus_rw      <= 1'b0;
      o_bus_address <= 32'd0;
      o_bus_wdata   <= 32'd0;
      o_busy        <= 1'b0;
      o_timeout     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_pa_request && (!i_pb_request || last_grant_b)) begin
            o_bus_request <= 1'b1;
            o_bus_rw      <= 1'b0;
            o_bus_address <= i_pa_address;
            o_bus_wdata   <= 32'd0;
            o_busy        <= 1'b1;
            watchdog      <= '0;
            state         <= BUS_A;
          end else if (i_pb_request) begin
            o_bus_request <= 1'b1;
            o_bus_rw      <= i_pb_rw;
            o_bus_address <= i_pb_address;
            o_bus_wdata   <= i_pb_wdata;
            o_busy        <= 1'b1;
            watchdog      <= '0;
            state         <= BUS_B;
          end
        end
        BUS_A, BUS_B: begin
          if (i_bus_ready || wd_expire) begin
            o_bus_request <= 1'b0;
            o_bus_rw      <= 1'b0;
            if (!i_bus_ready) o_timeout <= 1'b1;
            if (state == BUS_A) begin
              o_pa_rdata   <= done_rdata;
              o_pa_ready   <= 1'b1;
              last_grant_b <= 1'b0;
            end else begin
              o_pb_rdata   <= done_rdata;
              o_pb_ready   <= 1'b1;
              last_grant_b <= 1'b1;
            end
            state <= RELEASE;
          end else if (watchdog != '1) begin
            watchdog <= watchdog + 1'b1;
          end
        end
        RELEASE: begin
          o_pa_ready <= 1'b0;
          o_pb_ready <= 1'b0;
          o_busy     <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Directed bench for cpu_bus_arbiter: cycle vector table plus hand-written
// sequences for contention, watchdog abort and reset mid-transfer.
module tb_cpu_bus_arbiter;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_pa_request, o_pa_ready;
  logic [31:0] i_pa_address, o_pa_rdata;
  logic        i_pb_request, i_pb_rw, o_pb_ready;
  logic [31:0] i_pb_address, i_pb_wdata, o_pb_rdata;
  logic        o_bus_request, o_bus_rw, i_bus_ready;
  logic [31:0] o_bus_address, i_bus_rdata, o_bus_wdata;
  logic        o_busy, o_timeout;

  always #5 clk = ~clk;

  cpu_bus_arbiter #(.TIMEOUT_CYCLES(8), .TIMEOUT_WIDTH(16)) dut (
    .i_clock(clk), .i_reset(i_reset),
    .i_pa_request(i_pa_request), .o_pa_ready(o_pa_ready),
    .i_pa_address(i_pa_address), .o_pa_rdata(o_pa_rdata),
    .i_pb_request(i_pb_request), .i_pb_rw(i_pb_rw), .o_pb_ready(o_pb_ready),
    .i_pb_address(i_pb_address), .i_pb_wdata(i_pb_wdata), .o_pb_rdata(o_pb_rdata),
    .o_bus_request(o_bus_request), .o_bus_rw(o_bus_rw), .i_bus_ready(i_bus_ready),
    .o_bus_address(o_bus_address), .i_bus_rdata(i_bus_rdata), .o_bus_wdata(o_bus_wdata),
    .o_busy(o_busy), .o_timeout(o_timeout)
  );

  typedef logic [133:0] obs_t;

  typedef struct packed {
    logic        pa_req;
    logic [31:0] pa_addr;
    logic        pb_req;
    logic        pb_rw;
    logic [31:0] pb_addr;
    logic [31:0] pb_wdata;
    logic        rdy;
    logic [31:0] rdata;
    obs_t        exp;
  } vec_t;

  int   n_vec = 0;
  int   n_err = 0;
  vec_t tbl [18];

  function automatic obs_t pack(input logic breq, input logic brw,
                                input logic [31:0] baddr, input logic [31:0] bwdata,
                                input logic par, input logic [31:0] pard,
                                input logic pbr, input logic [31:0] pbrd,
                                input logic busy, input logic tmo);
    return {breq, brw, baddr, bwdata, par, pard, pbr, pbrd, busy, tmo};
  endfunction

  function automatic obs_t actual();
    return pack(o_bus_request, o_bus_rw, o_bus_address, o_bus_wdata, o_pa_ready,
                o_pa_rdata, o_pb_ready, o_pb_rdata, o_busy, o_timeout);
  endfunction

  function automatic vec_t mk(input logic pa_req, input logic [31:0] pa_addr,
                              input logic pb_req, input logic pb_rw,
                              input logic [31:0] pb_addr, input logic [31:0] pb_wdata,
                              input logic rdy, input logic [31:0] rdata, input obs_t exp);
    return '{pa_req, pa_addr, pb_req, pb_rw, pb_addr, pb_wdata, rdy, rdata, exp};
  endfunction

  task automatic check(input string name, input obs_t exp);
    obs_t got;
    got = actual();
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got {req,rw,addr,wdata,pa_rdy,pa_rdata,pb_rdy,pb_rdata,busy,tmo}=%h, expected %h",
               name, got, exp);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic pa_req, input logic [31:0] pa_addr,
                       input logic pb_req, input logic pb_rw,
                       input logic [31:0] pb_addr, input logic [31:0] pb_wdata,
                       input logic rdy, input logic [31:0] rdata);
    i_pa_request = pa_req;
    i_pa_address = pa_addr;
    i_pb_request = pb_req;
    i_pb_rw      = pb_rw;
    i_pb_address = pb_addr;
    i_pb_wdata   = pb_wdata;
    i_bus_ready  = rdy;
    i_bus_rdata  = rdata;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    i_reset = 1'b1;
    step();
    step();
    i_reset = 1'b0;
  endtask

  initial begin
    logic [31:0] order [8];
    int          grants;
    logic        prev_req;

    // Cycle table: inputs before the edge, registered outputs after it.
    tbl[0]  = mk(1'b1, 32'h9C, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,
                 pack(1'b1, 1'b0, 32'h9C, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0));
    tbl[1]  = mk(1'b1, 32'h9C, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,
                 pack(1'b1, 1'b0, 32'h9C, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0));
    tbl[2]  = tbl[1];
    tbl[3]  = mk(1'b1, 32'h9C, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h13,
                 pack(1'b0, 1'b0, 32'h9C, 32'h0, 1'b1, 32'h13, 1'b0, 32'h0, 1'b1, 1'b0));
    tbl[4]  = mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,
                 pack(1'b0, 1'b0, 32'h9C, 32'h0, 1'b0, 32'h13, 1'b0, 32'h0, 1'b0, 1'b0));
    tbl[5]  = mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h55,
                 pack(1'b0, 1'b0, 32'h9C, 32'h0, 1'b0, 32'h13, 1'b0, 32'h0, 1'b0, 1'b0));
    tbl[6]  = mk(1'b0, 32'h0, 1'b1, 1'b1, 32'h1000, 32'hDEADBEEF, 1'b0, 32'h0,
                 pack(1'b1, 1'b1, 32'h1000, 32'hDEADBEEF, 1'b0, 32'h13, 1'b0, 32'h0, 1'b1, 1'b0));
    tbl[7]  = mk(1'b0, 32'h0, 1'b1, 1'b1, 32'h1000, 32'hDEADBEEF, 1'b1, 32'hAAAA5555,
                 pack(1'b0, 1'b0, 32'h1000, 32'hDEADBEEF, 1'b0, 32'h13, 1'b1, 32'hAAAA5555, 1'b1, 1'b0));
    tbl[8]  = mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h77,
                 pack(1'b0, 1'b0, 32'h1000, 32'hDEADBEEF, 1'b0, 32'h13, 1'b0, 32'hAAAA5555, 1'b0, 1'b0));
    tbl[9]  = mk(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,
                 pack(1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 32'h13, 1'b0, 32'hAAAA5555, 1'b1, 1'b0));
    tbl[10] = mk(1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,
                 pack(1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 32'h13, 1'b0, 32'hAAAA5555, 1'b1, 1'b0));
    tbl[11] = tbl[10];
    tbl[12] = mk(1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h12345678,
                 pack(1'b0, 1'b0, 32'h100, 32'h0, 1'b1, 32'h12345678, 1'b0, 32'hAAAA5555, 1'b1, 1'b0));
    tbl[13] = mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,
                 pack(1'b0, 1'b0, 32'h100, 32'h0, 1'b0, 32'h12345678, 1'b0, 32'hAAAA5555, 1'b0, 1'b0));
    tbl[14] = mk(1'b0, 32'h0, 1'b1, 1'b0, 32'h2000, 32'h11, 1'b0, 32'h0,
                 pack(1'b1, 1'b0, 32'h2000, 32'h11, 1'b0, 32'h12345678, 1'b0, 32'hAAAA5555, 1'b1, 1'b0));
    tbl[15] = mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h2000, 32'h11, 1'b0, 32'h0,
                 pack(1'b1, 1'b0, 32'h2000, 32'h11, 1'b0, 32'h12345678, 1'b0, 32'hAAAA5555, 1'b1, 1'b0));
    tbl[16] = mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hCAFEF00D,
                 pack(1'b0, 1'b0, 32'h2000, 32'h11, 1'b0, 32'h12345678, 1'b1, 32'hCAFEF00D, 1'b1, 1'b0));
    tbl[17] = mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,
                 pack(1'b0, 1'b0, 32'h2000, 32'h11, 1'b0, 32'h12345678, 1'b0, 32'hCAFEF00D, 1'b0, 1'b0));

    @(negedge clk);
    do_reset();
    check("reset values", obs_t'(0));

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].pa_req, tbl[i].pa_addr, tbl[i].pb_req, tbl[i].pb_rw,
            tbl[i].pb_addr, tbl[i].pb_wdata, tbl[i].rdy, tbl[i].rdata);
      step();
      check($sformatf("vector %0d", i), tbl[i].exp);
    end

    // Contention: both ports always requesting, bus answers one cycle after request.
    do_reset();
    drive(1'b1, 32'hA0, 1'b1, 1'b0, 32'hB0, 32'h0, 1'b0, 32'h0);
    grants   = 0;
    prev_req = 1'b0;
    for (int cyc = 0; cyc < 200 && grants < 8; cyc++) begin
      step();
      if (o_bus_request && !prev_req) begin
        order[grants] = o_bus_address;
        grants++;
      end
      prev_req    = o_bus_request;
      i_bus_ready = o_bus_request;
      i_bus_rdata = o_bus_address + 32'd1;
    end
    check_val("contention grant count", 32'(grants), 32'd8);
    for (int k = 0; k < grants; k++)
      check_val($sformatf("contention grant %0d", k), order[k], (k % 2 == 0) ? 32'hA0 : 32'hB0);
    i_pa_request = 1'b0;
    i_pb_request = 1'b0;
    step();
    check_val("contention last pb_ready", 32'(o_pb_ready), 32'd1);
    check_val("contention pb_rdata", o_pb_rdata, 32'hB1);
    check_val("contention pa_rdata", o_pa_rdata, 32'hA1);
    i_bus_ready = 1'b0;
    step();
    step();

    // Watchdog: bus never answers, abort on the 8th edge after grant.
    drive(1'b1, 32'h300, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    step();
    check_val("timeout grant address", o_bus_address, 32'h300);
    for (int k = 1; k < 8; k++) begin
      step();
      check_val($sformatf("timeout wait %0d {req,pa_rdy,tmo}", k),
                32'({o_bus_request, o_pa_ready, o_timeout}), 32'b100);
    end
    step();
    check("timeout abort", pack(1'b0, 1'b0, 32'h300, 32'h0, 1'b1, 32'h0, 1'b0, 32'hB1, 1'b1, 1'b1));
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    step();
    drive(1'b1, 32'h400, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    step();
    drive(1'b1, 32'h400, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h99);
    step();
    check("read after timeout", pack(1'b0, 1'b0, 32'h400, 32'h0, 1'b1, 32'h99, 1'b0, 32'hB1, 1'b1, 1'b1));
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    step();
    step();
    check_val("timeout sticky", 32'(o_timeout), 32'd1);

    // Reset while B owns the bus; last grant was A, so only a reset restores A priority.
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h500, 32'h5, 1'b0, 32'h0);
    step();
    check("bus_b write in flight", pack(1'b1, 1'b1, 32'h500, 32'h5, 1'b0, 32'h99, 1'b0, 32'hB1, 1'b1, 1'b1));
    i_reset     = 1'b1;
    i_bus_ready = 1'b1;
    i_bus_rdata = 32'hEE;
    step();
    check("reset mid-transfer", obs_t'(0));
    i_reset = 1'b0;
    drive(1'b1, 32'h600, 1'b1, 1'b0, 32'h700, 32'h0, 1'b0, 32'h0);
    step();
    check("post-reset contention grants A",
          pack(1'b1, 1'b0, 32'h600, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_bus_arbiter.md
Name: cpu_bus_arbiter

Overview:
- Shares the single CPU memory bus between two masters: port A (instruction fetch / I-cache refill, read-only) and port B (data load/store unit, read/write).
- Registered, one transfer at a time. Round-robin on contention. Watchdog aborts transfers the bus never acknowledges.
- Sits between the CPU pipeline caches and the SoC bus. Same request/ready level handshake on both sides.

Parameters:
- TIMEOUT_CYCLES, 1024, max cycles waiting for i_bus_ready before abort; 0 disables watchdog.
- TIMEOUT_WIDTH, 16, width of watchdog counter; must hold TIMEOUT_CYCLES.

Ports:
- i_clock  in  1  single clock; all logic on posedge.
- i_reset  in  1  synchronous, active-high reset.
- i_pa_request  in  1  port A transfer request, level; held until o_pa_ready seen.
- o_pa_ready  out  1  one-cycle completion pulse to port A.
- i_pa_address  in  32  port A byte address.
- o_pa_rdata  out  32  port A read data, valid while o_pa_ready=1, held afterwards.
- i_pb_request  in  1  port B transfer request, level.
- i_pb_rw  in  1  port B direction: 1=write, 0=read.
- o_pb_ready  out  1  one-cycle completion pulse to port B.
- i_pb_address  in  32  port B byte address.
- i_pb_wdata  in  32  port B write data.
- o_pb_rdata  out  32  port B read data, same rules as A.
- o_bus_request  out  1  bus request, level.
- o_bus_rw  out  1  bus direction: 1=write.
- i_bus_ready  in  1  bus completion; rdata valid same cycle.
- o_bus_address  out  32  bus address.
- i_bus_rdata  in  32  bus read data.
- o_bus_wdata  out  32  bus write data.
- o_busy  out  1  high in any state other than IDLE.
- o_timeout  out  1  sticky flag, set on any watchdog abort, cleared only by reset.

Behaviour:
- All outputs registered. Reset values:
  - All 1-bit outputs 0.
  - o_bus_address, o_bus_wdata, o_pa_rdata, o_pb_rdata all 0.
  - State IDLE, last_grant=B (so A wins the first contention), watchdog=0.
- States:
  - IDLE(0): no bus activity.
    - Only A requesting -> grant A. Only B requesting -> grant B.
    - Both requesting -> grant the port not equal to last_grant.
    - Grant edge: o_bus_request<=1; latch address, plus rw/wdata for B. Port A always drives rw=0 and wdata=0. Go to BUS_A(1) or BUS_B(2). Watchdog<=0.
  - BUS_A / BUS_B: hold all bus outputs stable. Requester address/data changes are ignored.
    - On i_bus_ready=1:
      - o_bus_request<=0 and o_bus_rw<=0.
      - Granted port's rdata<=i_bus_rdata; on a write, port B's rdata is also loaded (don't-care value).
      - Granted port's ready<=1. last_grant<=this port. Go to RELEASE(3).
    - Otherwise watchdog increments. When TIMEOUT_CYCLES!=0 and watchdog==TIMEOUT_CYCLES-1 without ready:
      - Same exit as completion, but rdata<=0 and o_timeout<=1.
  - RELEASE(3): clear both ready outputs; go to IDLE. No grant is issued this cycle.
- Latency:
  - Request high before edge N -> o_bus_request high after edge N.
  - i_bus_ready sampled at edge M -> port ready high for exactly one cycle after M.
  - Next grant is issued no earlier than edge M+2.
  - Idle back-to-back single-port turnaround is 3 edges of overhead.
- Requester obligation: drop request at the edge where it samples ready=1, or reissue a new request. At IDLE, a request is always treated as new.
- A requester dropping its request mid-transfer is a protocol violation. The arbiter still completes the transfer and pulses ready.
- i_bus_ready while IDLE or RELEASE is ignored.
- Reset mid-transfer: next edge returns to reset values. o_bus_request drops immediately, with no ready pulse to either port.
- Watchdog counter saturates; it never wraps within a transfer.

Test Plan:
- Single read A: A requests 0x0000009C. Bus ready 3 cycles after o_bus_request with rdata 0x00000013. Expect o_bus_address=0x9C, rw=0, o_pa_ready one cycle with o_pa_rdata=0x13, o_pb_ready never set.
- Write B: B requests rw=1, addr 0x1000, wdata 0xDEADBEEF. Expect o_bus_rw=1, o_bus_wdata=0xDEADBEEF, o_pb_ready single pulse, o_bus_rw back to 0 after.
- Contention: A and B both request continuously, re-requesting after each ready, bus ready 1 cycle after request. Expect grant order A,B,A,B over 8 transfers and no port served twice consecutively.
- Stability: change i_pa_address from 0x100 to 0x200 mid-transfer. Expect o_bus_address stays 0x100 until ready.
- Timeout: TIMEOUT_CYCLES=8, bus never ready. Expect abort 8 cycles after grant, o_pa_ready pulse with rdata 0, o_timeout=1 and still 1 after a later good transfer.
- Reset mid-transfer: assert i_reset while in BUS_B. Expect all outputs 0 next cycle and no ready pulse. After reset, contention grants A first.
